// File: rtl/counter_pkg.sv
// Shared definitions for the counter arbiter: FSM encoding and default widths.
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_CNT_W   = 4;
   localparam int unsigned DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/interval_counter.sv
// Shared up-counter datapath: synchronous clear has priority over enable.
module interval_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] out
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, increment or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out = cnt_q;

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin scheduler that lends one interval counter to NUM_REQ requesters, one run at a time.
module counter_arbiter
   import counter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
   parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] len,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         out
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Rotate requests so ptr+1 sits at bit 0, take the lowest set bit, rotate the index back.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [PTR_W-1:0]   p);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      int unsigned          off;
      int unsigned          sel;
      off = 32'(p) + 32'd1;
      if (off >= NUM_REQ) begin
         off = off - NUM_REQ;
      end
      dbl = {r, r};
      rot = dbl[off +: NUM_REQ];
      sel = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel = k;
         end
      end
      sel = sel + off;
      if (sel >= NUM_REQ) begin
         sel = sel - NUM_REQ;
      end
      return PTR_W'(sel);
   endfunction

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [PTR_W-1:0]   pick;
   logic [CNT_W-1:0]   len_sel;
   logic               cnt_clr;
   logic               cnt_en;

   // Next-state, grant bookkeeping and counter control.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      pick    = rr_pick(req, ptr_q);
      len_sel = len[32'(pick)*CNT_W +: CNT_W];
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               idx_d   = pick;
               grant_d = NUM_REQ'(1) << pick;
               len_d   = len_sel;
               cnt_clr = 1'b1;
               state_d = (len_sel != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (!req[idx_q]) begin
               // Requester gave up: discard the run, counter holds, no done pulse.
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = idx_q;
            end else begin
               cnt_en = 1'b1;
               if (out == len_q - CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = idx_q;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // FSM and arbitration state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         idx_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
      end
   end

   interval_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .out   (out)
   );

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter; outputs are sampled on the falling clock edge.
module tb_counter_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned CNT_W   = 4;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*CNT_W-1:0] len;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic                     done;
   logic [CNT_W-1:0]         out;

   int n_cmp;
   int n_err;

   counter_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      req   = '0;
      len   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [NUM_REQ-1:0] exp_g;
      n_cmp = 0;
      n_err = 0;

      // 1. Reset held with all requests pending.
      reset = 1'b0;
      req   = 4'b1111;
      len   = {4'd2, 4'd2, 4'd2, 4'd2};
      repeat (3) step();
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
      check_eq("rst_out", 32'(out), 32'h0);
      reset = 1'b1;
      step();
      check_eq("rst_first_grant", 32'(grant), 32'h1);

      // 2. Single request, len 5.
      apply_reset();
      req = 4'b0100;
      len[2*CNT_W +: CNT_W] = 4'd5;
      for (int k = 0; k <= 5; k++) begin
         step();
         check_eq("single_grant", 32'(grant), 32'b0100);
         check_eq("single_out", 32'(out), k);
         check_eq("single_done", 32'(done), 32'(k == 5));
      end
      step();
      check_eq("single_gap_grant", 32'(grant), 32'h0);
      check_eq("single_gap_busy", 32'(busy), 32'h0);
      check_eq("single_gap_out", 32'(out), 32'd5);

      // 4. Zero length, straight after the previous run so the clear is visible.
      req = 4'b0010;
      len = '0;
      step();
      check_eq("zero_grant", 32'(grant), 32'b0010);
      check_eq("zero_done", 32'(done), 32'h1);
      check_eq("zero_out", 32'(out), 32'h0);
      check_eq("zero_busy", 32'(busy), 32'h1);
      req = '0;
      step();
      check_eq("zero_end_grant", 32'(grant), 32'h0);
      check_eq("zero_end_busy", 32'(busy), 32'h0);

      // 3. Round-robin, all four requesting with len 2.
      apply_reset();
      req = 4'b1111;
      len = {4'd2, 4'd2, 4'd2, 4'd2};
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         for (int c = 0; c < 4; c++) begin
            step();
            check_eq("rr_grant", 32'(grant), (c < 3) ? 32'(exp_g) : 32'h0);
            if (c < 3) begin
               check_eq("rr_out", 32'(out), c);
               check_eq("rr_done", 32'(done), 32'(c == 2));
            end
         end
      end
      req = '0;

      // 5. Abort of requester 3 at out 4; requester 0 is next.
      apply_reset();
      req = 4'b1000;
      len[3*CNT_W +: CNT_W] = 4'd10;
      for (int k = 0; k <= 4; k++) begin
         step();
         check_eq("abort_grant", 32'(grant), 32'b1000);
         check_eq("abort_out", 32'(out), k);
      end
      req = 4'b0001;
      len[0 +: CNT_W] = 4'd3;
      step();
      check_eq("abort_idle_grant", 32'(grant), 32'h0);
      check_eq("abort_no_done", 32'(done), 32'h0);
      check_eq("abort_hold_out", 32'(out), 32'd4);
      step();
      check_eq("abort_next_grant", 32'(grant), 32'b0001);
      check_eq("abort_next_out", 32'(out), 32'h0);

      // 6. Async reset mid-run, then a full-length run with no wrap.
      apply_reset();
      req = 4'b0001;
      len[0 +: CNT_W] = 4'd15;
      for (int k = 0; k <= 7; k++) begin
         step();
         check_eq("pre_arst_out", 32'(out), k);
      end
      reset = 1'b0;
      #1;
      check_eq("arst_out", 32'(out), 32'h0);
      check_eq("arst_grant", 32'(grant), 32'h0);
      check_eq("arst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         step();
         check_eq("max_grant", 32'(grant), 32'b0001);
         check_eq("max_out", 32'(out), k);
         check_eq("max_done", 32'(done), 32'(k == 15));
      end
      req = '0;
      step();
      check_eq("max_end_grant", 32'(grant), 32'h0);
      check_eq("max_end_out", 32'(out), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
